// File: rtl/sms_preload_ctrl.sv
// SMS SRAM image preloader: streams words into ISRAM or SMS0 with byte-swapped lanes, then releases the CPU.
// Optional macro SMS_PRELOAD_ZERO_FILL_EN zero-fills the rest of the target SRAM after the image.
module sms_preload_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384
) (
  input  logic              hclk,
  input  logic              hrst,
  input  logic              start,
  input  logic              tgt_sel,
  input  logic [ADDR_W:0]   word_cnt,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  output logic              mem_isram_cs,
  output logic              mem_dsram_cs,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst_hold
);

  typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  state_t          state;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W:0] wcnt;
  logic            tgt;
  logic [ADDR_W:0] cnt_nxt;

  assign cnt_nxt = cnt + ONE;

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state        <= IDLE;
      cnt          <= '0;
      wcnt         <= '0;
      tgt          <= 1'b0;
      s_ready      <= 1'b0;
      mem_isram_cs <= 1'b0;
      mem_dsram_cs <= 1'b0;
      mem_wen      <= 4'h0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      cpu_rst_hold <= 1'b1;
    end else begin
      // Write strobes and done are single-cycle pulses unless re-asserted below.
      mem_isram_cs <= 1'b0;
      mem_dsram_cs <= 1'b0;
      mem_wen      <= 4'h0;
      done         <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (word_cnt > DEPTH_C) begin
              err <= 1'b1;
            end else begin
              err          <= 1'b0;
              busy         <= 1'b1;
              cpu_rst_hold <= 1'b1;
              tgt          <= tgt_sel;
              wcnt         <= word_cnt;
              cnt          <= '0;
`ifdef SMS_PRELOAD_ZERO_FILL_EN
              if (word_cnt == '0) begin
                // Empty image: first zero write goes out right away.
                state        <= FILL;
                mem_isram_cs <= ~tgt_sel;
                mem_dsram_cs <= tgt_sel;
                mem_wen      <= 4'hF;
                mem_addr     <= '0;
                mem_wdata    <= '0;
                cnt          <= ONE;
              end else begin
                state   <= LOAD;
                s_ready <= 1'b1;
              end
`else
              state   <= LOAD;
              s_ready <= (word_cnt != '0);
`endif
            end
          end
        end
        LOAD: begin
          if (cnt == wcnt) begin
`ifdef SMS_PRELOAD_ZERO_FILL_EN
            if (cnt != DEPTH_C) begin
              state        <= FILL;
              mem_isram_cs <= ~tgt;
              mem_dsram_cs <= tgt;
              mem_wen      <= 4'hF;
              mem_addr     <= cnt[ADDR_W-1:0];
              mem_wdata    <= '0;
              cnt          <= cnt_nxt;
            end else begin
              state        <= DONE;
              done         <= 1'b1;
              busy         <= 1'b0;
              cpu_rst_hold <= 1'b0;
            end
`else
            state        <= DONE;
            done         <= 1'b1;
            busy         <= 1'b0;
            cpu_rst_hold <= 1'b0;
`endif
          end else if (s_valid && s_ready) begin
            mem_isram_cs <= ~tgt;
            mem_dsram_cs <= tgt;
            mem_wen      <= 4'hF;
            mem_addr     <= cnt[ADDR_W-1:0];
            mem_wdata    <= {s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]};
            cnt          <= cnt_nxt;
            // Drop ready right after the last handshake so no extra word is taken.
            if (cnt_nxt == wcnt) s_ready <= 1'b0;
          end
        end
`ifdef SMS_PRELOAD_ZERO_FILL_EN
        FILL: begin
          if (cnt == DEPTH_C) begin
            state        <= DONE;
            done         <= 1'b1;
            busy         <= 1'b0;
            cpu_rst_hold <= 1'b0;
          end else begin
            mem_isram_cs <= ~tgt;
            mem_dsram_cs <= tgt;
            mem_wen      <= 4'hF;
            mem_addr     <= cnt[ADDR_W-1:0];
            mem_wdata    <= '0;
            cnt          <= cnt_nxt;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sms_preload_ctrl.sv
// Randomized bench for sms_preload_ctrl; expected SRAM write streams come from a queue-based image model.
module tb_sms_preload_ctrl;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
`ifdef SMS_PRELOAD_ZERO_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  logic              hclk = 1'b0;
  logic              hrst = 1'b1;
  logic              start = 1'b0;
  logic              tgt_sel = 1'b0;
  logic [ADDR_W:0]   word_cnt = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [31:0]       s_data = '0;
  logic              mem_isram_cs, mem_dsram_cs;
  logic [3:0]        mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy, done, err, cpu_rst_hold;

  sms_preload_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .hclk(hclk), .hrst(hrst), .start(start), .tgt_sel(tgt_sel), .word_cnt(word_cnt),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mem_isram_cs(mem_isram_cs), .mem_dsram_cs(mem_dsram_cs), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err),
    .cpu_rst_hold(cpu_rst_hold)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    bit          tgt;
    int          addr;
    logic [31:0] data;
    logic [3:0]  wen;
    int          cyc;
  } wr_t;

  wr_t         wq[$];
  wr_t         exp_q[$];
  logic [31:0] words[$];
  int cyc, done_cnt, done_cyc, hold_bad, hold_early, both_cs, late_ready;
  int start_cyc, acc;
  logic busy_at_start, rdy_at_start;
  int tests = 0, fails = 0;

  // One clock: advance past the edge and log what the DUT presents.
  task automatic step();
    wr_t w;
    @(posedge hclk); #1;
    cyc++;
    if (mem_isram_cs || mem_dsram_cs) begin
      w.tgt = mem_dsram_cs; w.addr = int'(mem_addr); w.data = mem_wdata;
      w.wen = mem_wen; w.cyc = cyc;
      wq.push_back(w);
    end
    if (mem_isram_cs && mem_dsram_cs) both_cs++;
    if (done) begin
      done_cnt++; done_cyc = cyc;
      if (cpu_rst_hold) hold_bad++;
    end
    if (busy && !cpu_rst_hold) hold_early++;
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) r = r | (((w >> (8*b)) & 32'hFF) << (8*(3-b)));
    return r;
  endfunction

  // Reference image: the n stream words at 0..n-1, then zeros to the top when fill is built in.
  function automatic void build_exp(input bit tgt, input int n);
    wr_t e;
    exp_q.delete();
    for (int k = 0; k < DEPTH; k++) begin
      if (k >= n && !FILL) break;
      e.tgt = tgt; e.addr = k; e.wen = 4'hF; e.cyc = 0;
      e.data = (k < n) ? bswap(words[k]) : 32'h0;
      exp_q.push_back(e);
    end
  endfunction

  function automatic int wr_diffs();
    int d;
    d = (wq.size() == exp_q.size()) ? 0 : 1;
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
      if (wq[i].tgt !== exp_q[i].tgt || wq[i].addr != exp_q[i].addr ||
          wq[i].data !== exp_q[i].data || wq[i].wen !== exp_q[i].wen) d++;
    return d;
  endfunction

  function automatic void clr_log();
    wq.delete(); done_cnt = 0; done_cyc = -1; hold_bad = 0; hold_early = 0;
    both_cs = 0; late_ready = 0; acc = 0;
  endfunction

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  // Drive one load request and stream words until done (bounded).
  task automatic run_load(input bit tgt, input int n, input int stall_pct,
                          input int stall_idx, input int stall_len, input int restart_idx);
    int  stall_left;
    bit  hsn, stall_used, restart_used;
    stall_left = 0; stall_used = 0; restart_used = 0;
    clr_log();
    tgt_sel = tgt; word_cnt = (ADDR_W+1)'(n); start = 1'b1;
    step();
    start = 1'b0; start_cyc = cyc; busy_at_start = busy; rdy_at_start = s_ready;
    for (int c = 0; c < 4*DEPTH + 50 && done_cnt == 0; c++) begin
      if (acc == stall_idx && !stall_used) begin stall_left = stall_len; stall_used = 1; end
      if (acc == restart_idx && !restart_used) begin
        start = 1'b1; word_cnt = (ADDR_W+1)'(DEPTH + 1); tgt_sel = ~tgt; restart_used = 1;
      end
      if (stall_left > 0) begin
        s_valid = 1'b0; stall_left--;
      end else if (acc < n && int'($urandom_range(99)) >= stall_pct) begin
        s_valid = 1'b1; s_data = words[acc];
      end else begin
        s_valid = 1'b0; s_data = $urandom;
      end
      if (acc >= n && s_ready) late_ready++;
      hsn = s_valid && s_ready;
      step();
      start = 1'b0; word_cnt = (ADDR_W+1)'(n); tgt_sel = tgt;
      if (hsn) acc++;
    end
    s_valid = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_reset();
    hrst = 1'b1; step(); step();
    tests++; if ({s_ready, mem_isram_cs, mem_dsram_cs, mem_wen} !== 7'b0) begin
      fails++; $display("FAIL reset_strobes: got %b want 0", {s_ready, mem_isram_cs, mem_dsram_cs, mem_wen}); end
    tests++; if (mem_addr !== '0 || mem_wdata !== '0) begin
      fails++; $display("FAIL reset_addr_data: got %h/%h want 0/0", mem_addr, mem_wdata); end
    tests++; if ({busy, done, err, cpu_rst_hold} !== 4'b0001) begin
      fails++; $display("FAIL reset_status: got %b want 0001", {busy, done, err, cpu_rst_hold}); end
    hrst = 1'b0; step();
  endtask

  task automatic test_isram_load();
    int exp_done;
    words.delete();
    words.push_back(32'h11223344); words.push_back(32'hAABBCCDD); words.push_back(32'h00000013);
    run_load(1'b0, 3, 0, -1, 0, -1);
    build_exp(1'b0, 3);
    tests++; if (busy_at_start !== 1'b1 || rdy_at_start !== 1'b1) begin
      fails++; $display("FAIL isram_accept: busy=%b ready=%b want 1/1", busy_at_start, rdy_at_start); end
    tests++; if (wq.size() < 3 || wq[0].data !== 32'h44332211 || wq[1].data !== 32'hDDCCBBAA ||
                 wq[2].data !== 32'h13000000) begin
      fails++; $display("FAIL isram_lanes: got %0d writes, first words not 44332211/DDCCBBAA/13000000"
                        , wq.size()); end
    tests++; if (wr_diffs() != 0 || both_cs != 0) begin
      fails++; $display("FAIL isram_image: %0d diffs (%0d writes, want %0d), both_cs=%0d",
                        wr_diffs(), wq.size(), exp_q.size(), both_cs); end
    tests++; if (wq.size() < 1 || wq[0].cyc != start_cyc + 1) begin
      fails++; $display("FAIL isram_latency: first write cycle wrong, want %0d", start_cyc + 1); end
    exp_done = start_cyc + (FILL ? DEPTH : 3) + 1;
    tests++; if (done_cnt != 1 || done_cyc != exp_done || hold_bad != 0 || hold_early != 0) begin
      fails++; $display("FAIL isram_done: cnt=%0d cyc=%0d want 1/%0d hold_bad=%0d early=%0d",
                        done_cnt, done_cyc - start_cyc, exp_done - start_cyc, hold_bad, hold_early); end
    tests++; if (busy !== 1'b0 || cpu_rst_hold !== 1'b0) begin
      fails++; $display("FAIL isram_idle: busy=%b hold=%b want 0/0", busy, cpu_rst_hold); end
  endtask

  task automatic test_stalled();
    rand_words(2);
    run_load(1'b1, 2, 0, 1, 5, -1);
    build_exp(1'b1, 2);
    tests++; if (wr_diffs() != 0) begin
      fails++; $display("FAIL stall_image: %0d diffs, got %0d writes want %0d", wr_diffs(), wq.size(), exp_q.size()); end
    tests++; if (late_ready != 0 || acc != 2) begin
      fails++; $display("FAIL stall_ready: late_ready=%0d accepted=%0d want 0/2", late_ready, acc); end
    tests++; if (wq.size() < 2 || wq[1].cyc - wq[0].cyc != 6) begin
      fails++; $display("FAIL stall_gap: second write gap wrong, want 6 cycles"); end
    tests++; if (done_cnt != 1 || done_cyc != wq[$].cyc + 1) begin
      fails++; $display("FAIL stall_done: cnt=%0d cyc=%0d want 1 one after last write", done_cnt, done_cyc); end
  endtask

  task automatic test_illegal();
    clr_log();
    tgt_sel = 1'b0; word_cnt = (ADDR_W+1)'(DEPTH + 1); start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    tests++; if (err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
      fails++; $display("FAIL illegal_err: err=%b busy=%b ready=%b want 1/0/0", err, busy, s_ready); end
    tests++; if (wq.size() != 0 || done_cnt != 0) begin
      fails++; $display("FAIL illegal_quiet: writes=%0d done=%0d want 0/0", wq.size(), done_cnt); end
    rand_words(2);
    run_load(1'b0, 2, 20, -1, 0, -1);
    tests++; if (err !== 1'b0) begin
      fails++; $display("FAIL illegal_clear: err=%b want 0", err); end
  endtask

  task automatic test_empty();
    int exp_done;
    words.delete();
    run_load(1'b1, 0, 0, -1, 0, -1);
    build_exp(1'b1, 0);
    exp_done = start_cyc + (FILL ? DEPTH : 1);
    tests++; if (wr_diffs() != 0) begin
      fails++; $display("FAIL empty_image: %0d diffs, got %0d writes want %0d", wr_diffs(), wq.size(), exp_q.size()); end
    tests++; if (done_cnt != 1 || done_cyc != exp_done || late_ready != 0) begin
      fails++; $display("FAIL empty_done: cnt=%0d at +%0d want 1 at +%0d, late_ready=%0d",
                        done_cnt, done_cyc - start_cyc, exp_done - start_cyc, late_ready); end
  endtask

  task automatic test_full();
    int zeros;
    rand_words(DEPTH);
    run_load(1'b0, DEPTH, 20, -1, 0, -1);
    build_exp(1'b0, DEPTH);
    zeros = 0;
    foreach (wq[i]) if (wq[i].addr == 0) zeros++;
    tests++; if (wr_diffs() != 0 || wq.size() != DEPTH) begin
      fails++; $display("FAIL full_image: %0d diffs, got %0d writes want %0d", wr_diffs(), wq.size(), DEPTH); end
    tests++; if (zeros != 1 || wq.size() == 0 || wq[$].addr != DEPTH - 1) begin
      fails++; $display("FAIL full_wrap: addr0 writes=%0d want 1, last addr not %0d", zeros, DEPTH - 1); end
    tests++; if (done_cnt != 1 || done_cyc != wq[$].cyc + 1 || late_ready != 0) begin
      fails++; $display("FAIL full_done: cnt=%0d late_ready=%0d want 1/0", done_cnt, late_ready); end
  endtask

  task automatic test_random();
    int n; bit t;
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(40, 1)); t = 1'($urandom_range(1));
      rand_words(n);
      run_load(t, n, 30, -1, 0, -1);
      build_exp(t, n);
      tests++; if (wr_diffs() != 0 || late_ready != 0 || done_cnt != 1 || done_cyc != wq[$].cyc + 1) begin
        fails++; $display("FAIL random_load%0d: n=%0d diffs=%0d late=%0d done=%0d", r, n, wr_diffs(),
                          late_ready, done_cnt); end
    end
  endtask

  task automatic test_restart_ignored();
    rand_words(12);
    run_load(1'b1, 12, 10, -1, 0, 5);
    build_exp(1'b1, 12);
    tests++; if (wr_diffs() != 0 || acc != 12 || err !== 1'b0 || done_cnt != 1) begin
      fails++; $display("FAIL restart_ignored: diffs=%0d accepted=%0d err=%b done=%0d want 0/12/0/1",
                        wr_diffs(), acc, err, done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit hsn; int k;
    rand_words(20);
    clr_log();
    tgt_sel = 1'b0; word_cnt = (ADDR_W+1)'(20); start = 1'b1;
    step(); start = 1'b0;
    k = 0;
    for (int c = 0; c < 100 && acc < 10; c++) begin
      s_valid = 1'b1; s_data = words[acc];
      hsn = s_ready;
      step();
      if (hsn) acc++;
      k++;
    end
    s_valid = 1'b0; hrst = 1'b1;
    step();
    tests++; if ({mem_isram_cs, mem_dsram_cs, mem_wen, s_ready} !== 7'b0 || busy !== 1'b0 ||
                 cpu_rst_hold !== 1'b1) begin
      fails++; $display("FAIL reset_mid: strobes=%b busy=%b hold=%b want 0/0/1",
                        {mem_isram_cs, mem_dsram_cs, mem_wen, s_ready}, busy, cpu_rst_hold); end
    tests++; if (wq.size() != 10 || done_cnt != 0) begin
      fails++; $display("FAIL reset_mid_partial: writes=%0d done=%0d want 10/0", wq.size(), done_cnt); end
    hrst = 1'b0; step();
  endtask

  initial begin
    cyc = 0;
    clr_log();
    test_reset();
    test_isram_load();
    test_stalled();
    test_illegal();
    test_empty();
    test_full();
    test_random();
    test_restart_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
